he_lut_remap: RTL and testbench

//  Downstream stage of histogram equalization. Holds the 256-entry transform table

---
 rtl/he_lut_remap.sv | 132 +++++++++++++
 tb/tb_he_lut_remap.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/he_lut_remap.sv
// he_lut_remap: 256-entry transform table and 1-cycle pixel remap stage.
// Define HE_REMAP_STATS_EN to add the sat_count saturated-beat counter.
module he_lut_remap #(
  parameter int IMAGE_WIDTH  = 660,
  parameter int IMAGE_HEIGHT = 440
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        lut_wr_en,
  input  logic [7:0]  lut_wr_addr,
  input  logic [7:0]  lut_wr_data,
  input  logic        lut_load_done,
  input  logic        frame_start,
  input  logic        in_valid,
  input  logic [7:0]  in_pixel,
  output logic        in_ready,
  output logic        out_valid,
  output logic [7:0]  out_pixel,
  output logic        out_last,
  input  logic        out_ready,
  output logic        frame_done,
  output logic        lut_wr_err
`ifdef HE_REMAP_STATS_EN
  ,
  output logic [31:0] sat_count
`endif
);

  localparam logic [31:0] NP    = 32'(IMAGE_WIDTH * IMAGE_HEIGHT);
  localparam logic [31:0] NP_M1 = NP - 32'd1;

  typedef enum logic [1:0] {
    S_LOAD,
    S_STREAM,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_lut [256];
  logic [31:0] r_in_cnt;
  logic [31:0] r_out_cnt;
  logic        r_out_valid;
  logic [7:0]  r_out_pixel;
  logic        r_out_last;
  logic        r_wr_err;
  logic        w_in_fire;
  logic        w_out_fire;
  logic        w_lut_we;
  logic        w_clr;
  logic        w_enter_stream;

  assign in_ready = (r_state == S_STREAM) && (r_in_cnt != NP) &&
                    (!r_out_valid || out_ready);
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = r_out_valid && out_ready;

  always_comb begin
    w_next   = r_state;
    w_lut_we = 1'b0;
    unique case (r_state)
      S_LOAD: begin
        w_lut_we = lut_wr_en;
        if (lut_load_done) w_next = S_STREAM;
      end
      S_STREAM: begin
        if (w_out_fire && r_out_cnt == NP_M1) w_next = S_DONE;
      end
      S_DONE: begin
        if (lut_wr_en) begin
          w_lut_we = 1'b1;
          w_next   = S_LOAD;
        end else if (frame_start) begin
          w_next = S_STREAM;
        end
      end
      default: w_next = S_LOAD;
    endcase
  end

  // every state change except the end of a frame restarts the counters
  assign w_clr          = (r_state != w_next) && (w_next != S_DONE);
  assign w_enter_stream = w_clr && (w_next == S_STREAM);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_LOAD;
      r_in_cnt    <= '0;
      r_out_cnt   <= '0;
      r_out_valid <= 1'b0;
      r_out_pixel <= '0;
      r_out_last  <= 1'b0;
      r_wr_err    <= 1'b0;
      for (int i = 0; i < 256; i++) r_lut[i] <= 8'(i);
    end else begin
      r_state <= w_next;
      if (w_lut_we) r_lut[lut_wr_addr] <= lut_wr_data;
      if (r_state == S_STREAM && lut_wr_en) r_wr_err <= 1'b1;
      if (w_in_fire) begin
        r_out_pixel <= r_lut[in_pixel];
        r_out_last  <= (r_in_cnt == NP_M1);
      end
      if (w_in_fire)       r_out_valid <= 1'b1;
      else if (w_out_fire) r_out_valid <= 1'b0;
      if (w_clr) begin
        r_in_cnt  <= '0;
        r_out_cnt <= '0;
      end else begin
        if (w_in_fire)  r_in_cnt  <= r_in_cnt + 32'd1;
        if (w_out_fire) r_out_cnt <= r_out_cnt + 32'd1;
      end
    end
  end

`ifdef HE_REMAP_STATS_EN
  logic [31:0] r_sat;
  always_ff @(posedge clk) begin
    if (reset || w_enter_stream)
      r_sat <= '0;
    else if (w_out_fire && (r_out_pixel == 8'hFF || r_out_pixel == 8'h00))
      r_sat <= r_sat + 32'd1;
  end
  assign sat_count = r_sat;
`endif

  assign out_valid  = r_out_valid;
  assign out_pixel  = r_out_pixel;
  assign out_last   = r_out_last;
  assign frame_done = (r_state == S_DONE);
  assign lut_wr_err = r_wr_err;

endmodule

// File: tb/tb_he_lut_remap.sv
// tb_he_lut_remap: randomized bench with a queue-based reference model.
// A small 8x4 frame keeps every test short.
module tb_he_lut_remap;
  localparam int W  = 8;
  localparam int H  = 4;
  localparam int NP = W * H;

  logic        clk = 1'b0;
  logic        reset;
  logic        lut_wr_en;
  logic [7:0]  lut_wr_addr;
  logic [7:0]  lut_wr_data;
  logic        lut_load_done;
  logic        frame_start;
  logic        in_valid;
  logic [7:0]  in_pixel;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_pixel;
  logic        out_last;
  logic        out_ready;
  logic        frame_done;
  logic        lut_wr_err;
`ifdef HE_REMAP_STATS_EN
  logic [31:0] sat_count;
`endif

  always #5 clk = ~clk;

  he_lut_remap #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H)) dut (
    .clk(clk), .reset(reset),
    .lut_wr_en(lut_wr_en), .lut_wr_addr(lut_wr_addr),
    .lut_wr_data(lut_wr_data), .lut_load_done(lut_load_done),
    .frame_start(frame_start),
    .in_valid(in_valid), .in_pixel(in_pixel), .in_ready(in_ready),
    .out_valid(out_valid), .out_pixel(out_pixel), .out_last(out_last),
    .out_ready(out_ready), .frame_done(frame_done),
    .lut_wr_err(lut_wr_err)
`ifdef HE_REMAP_STATS_EN
    , .sat_count(sat_count)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit checking = 1'b0;

  logic [7:0] m_lut [256];
  int         m_phase;
  int         m_acc;
  int         m_sat;
  bit         m_err;
  logic [8:0] m_q [$];
  logic [7:0] got_log [$];
  int         got_last_idx;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model: phase 0 load, 1 stream, 2 done; queue holds {last,pixel}
  always @(posedge clk) begin
    bit ot;
    bit it;
    logic [8:0] b;
    if (reset) begin
      m_phase = 0;
      for (int i = 0; i < 256; i++) m_lut[i] = 8'(i);
      m_q.delete();
      m_acc = 0;
      m_sat = 0;
      m_err = 1'b0;
    end else begin
      case (m_phase)
        0: begin
          if (lut_wr_en) m_lut[lut_wr_addr] = lut_wr_data;
          if (lut_load_done) begin
            m_phase = 1; m_acc = 0; m_sat = 0;
          end
        end
        1: begin
          if (lut_wr_en) m_err = 1'b1;
          ot = (m_q.size() != 0) && out_ready;
          it = in_valid && (m_acc < NP) && (m_q.size() == 0 || out_ready);
          if (ot) begin
            b = m_q.pop_front();
            got_log.push_back(out_pixel);
            if (out_last) got_last_idx = got_log.size();
            if (b[7:0] == 8'h00 || b[7:0] == 8'hFF) m_sat++;
            if (b[8]) m_phase = 2;
          end
          if (it) begin
            m_q.push_back({m_acc == NP - 1, m_lut[in_pixel]});
            m_acc++;
          end
        end
        default: begin
          if (lut_wr_en) begin
            m_lut[lut_wr_addr] = lut_wr_data;
            m_phase = 0; m_acc = 0;
          end else if (frame_start) begin
            m_phase = 1; m_acc = 0; m_sat = 0;
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      chk("out_valid", out_valid, m_q.size() != 0);
      if (m_q.size() != 0) begin
        chk("out_pixel", out_pixel, m_q[0][7:0]);
        chk("out_last", out_last, m_q[0][8]);
      end
      chk("in_ready", in_ready,
          m_phase == 1 && m_acc < NP && (m_q.size() == 0 || out_ready));
      chk("frame_done", frame_done, m_phase == 2);
      chk("lut_wr_err", lut_wr_err, m_err);
`ifdef HE_REMAP_STATS_EN
      chk("sat_count", sat_count, m_sat);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    lut_wr_en = 0; lut_load_done = 0; frame_start = 0;
    in_valid = 0; out_ready = 1;
  endtask

  task automatic pulse_load_done();
    lut_load_done = 1; tick(); lut_load_done = 0;
  endtask

  task automatic pulse_frame_start();
    frame_start = 1; tick(); frame_start = 0;
  endtask

  // kind 0: reversed table (with an overwritten addr 7); kind 1: all zero
  task automatic load_lut(input int kind);
    lut_wr_en = 1; lut_wr_addr = 8'd7; lut_wr_data = 8'h55; tick();
    for (int i = 0; i < 256; i++) begin
      lut_wr_addr = 8'(i);
      lut_wr_data = (kind == 0) ? 8'(255 - i) : 8'h00;
      lut_load_done = (i == 255);
      tick();
    end
    lut_wr_en = 0; lut_load_done = 0;
  endtask

  function automatic logic [7:0] pix(input int mode, input int idx);
    case (mode)
      0: return 8'(idx);
      1: return ($urandom_range(0, 3) == 0) ? 8'd5 : 8'($urandom);
      2: begin
        if (idx == 0) return 8'h10;
        if (idx == 1) return 8'h80;
        if (idx == 2) return 8'hFF;
        return 8'($urandom);
      end
      3: return 8'(idx * 7);
      default: return 8'd5;
    endcase
  endfunction

  task automatic stream_frame(input int mode);
    int idx;
    int cyc;
    int stall;
    bit acc;
    logic [7:0] held;
    idx = 0; cyc = 0; stall = 0; held = '0;
    got_log.delete();
    got_last_idx = 0;
    while (!frame_done && cyc < 2000) begin
      in_valid  = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (mode == 3 && idx == 10 && stall < 5) begin
        out_ready = 1'b0;
        stall++;
      end
      lut_wr_en   = (mode == 1 && cyc == 4);
      lut_wr_addr = 8'd5;
      lut_wr_data = 8'h00;
      in_pixel    = pix(mode, idx);
      @(negedge clk);
      acc = in_valid && in_ready;
      if (mode == 3 && !out_ready) begin
        if (stall == 1) held = out_pixel;
        else chk("stall_hold", out_pixel, held);
      end
      tick();
      if (acc) idx++;
      cyc++;
    end
    lut_wr_en = 0;
    in_valid  = 0;
    out_ready = 1;
    chk("frame_timeout", frame_done, 1);
  endtask

  initial begin
    idle();
    reset = 1; in_pixel = 0; lut_wr_addr = 0; lut_wr_data = 0;
    tick();
    checking = 1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_pixel", out_pixel, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_wr_err", lut_wr_err, 0);
    tick();
    reset = 0;

    pulse_load_done();
    stream_frame(0);
    chk("t1_count", got_log.size(), NP);
    chk("t1_last_idx", got_last_idx, NP);
    chk("t1_pix31", got_log[31], 8'd31);
    chk("t1_pix0", got_log[0], 8'd0);

    load_lut(0);
    stream_frame(2);
    chk("t2_pix0", got_log[0], 8'hEF);
    chk("t2_pix1", got_log[1], 8'h7F);
    chk("t2_pix2", got_log[2], 8'h00);

    pulse_frame_start();
    stream_frame(3);
    chk("t3_count", got_log.size(), NP);
    chk("t5_last_idx", got_last_idx, NP);
    chk("t3_pix1", got_log[1], 8'd248);

    pulse_frame_start();
    stream_frame(1);
    chk("t4_wr_err", lut_wr_err, 1);
    lut_wr_en = 1; lut_wr_addr = 8'd5; lut_wr_data = 8'h42; frame_start = 1;
    tick();
    idle();
    chk("t4_left_done", frame_done, 0);
    pulse_load_done();
    stream_frame(4);
    chk("t4_lut5", got_log[0], 8'h42);

    pulse_frame_start();
    in_valid = 1;
    for (int i = 0; i < 10; i++) begin
      in_pixel = 8'($urandom);
      tick();
    end
    reset = 1;
    tick();
    reset = 0;
    idle();
    chk("t6_out_valid", out_valid, 0);
    chk("t6_out_pixel", out_pixel, 0);
    chk("t6_frame_done", frame_done, 0);
    chk("t6_wr_err", lut_wr_err, 0);
    chk("t6_in_ready", in_ready, 0);
    pulse_load_done();
    stream_frame(0);
    chk("t6_identity", got_log[20], 8'd20);

    load_lut(1);
    stream_frame(1);
`ifdef HE_REMAP_STATS_EN
    chk("t6_sat", sat_count, NP);
`endif
    chk("t6_zero", got_log[NP-1], 8'h00);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
